addsub_arbiter: RTL and testbench

Round-robin scheduler that shares one 32-bit ripple add/sub datapath among NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake, sequences it through the datapath and returns a registered, tagged response with carry and signed-overflow flags. The block sits between the requesting units and the single shared add/sub unit.

---
 rtl/addsub_arbiter_pkg.sv | 19 +
 rtl/addsub_arbiter_fa_addsub.sv | 28 ++
 rtl/addsub_arbiter_rr_pick.sv | 41 ++++
 rtl/addsub_arbiter.sv | 170 +++++++++++++++++
 tb/tb_addsub_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: FSM encoding, default widths and
// the round-robin distance helper.
package addsub_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Distance of requester i from the round-robin pointer, wrapping modulo n.
  function automatic int rr_dist(input int i, input int ptr, input int n);
    return (i >= ptr) ? (i - ptr) : (i + n - ptr);
  endfunction

endpackage

// File: rtl/addsub_arbiter_fa_addsub.sv
// Full-adder ripple add/sub datapath: B is inverted and carry-in forced to 1
// for subtraction.
module addsub_arbiter_fa_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  assign b_eff = b_i ^ {WIDTH{sub_i}};
  assign c[0]  = sub_i;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum_o[gi] = a_i[gi] ^ b_eff[gi] ^ c[gi];
    assign c[gi+1]   = (a_i[gi] & b_eff[gi]) | (c[gi] & (a_i[gi] ^ b_eff[gi]));
  end

  assign carry_o    = c[WIDTH];
  assign overflow_o = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/addsub_arbiter_rr_pick.sv
// Combinational round-robin selector: the valid requester nearest to rr_ptr
// (searching upward with wrap) wins.
module addsub_arbiter_rr_pick
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_valid_o
);

  int best_d;
  int d;

  always_comb begin
    best_d      = int'(NUM_REQ);
    d           = 0;
    winner_o    = '0;
    any_valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = rr_dist(i, int'(rr_ptr_i), int'(NUM_REQ));
      if (req_valid_i[i] && (d < best_d)) begin
        best_d      = d;
        winner_o    = ID_W'(i);
        any_valid_o = 1'b1;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = any_valid_o && (winner_o == ID_W'(i));
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one ripple add/sub unit among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with ADDSUB_ARBITER_STATS_EN.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic                     busy
`ifdef ADDSUB_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_count
`endif
);

  state_e             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sub_q;
  logic [ID_W-1:0]    tag_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_carry_q;
  logic               rsp_overflow_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sub;
  logic [WIDTH-1:0]   dp_sum;
  logic               dp_carry;
  logic               dp_overflow;

  addsub_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  addsub_arbiter_fa_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i        (a_q),
    .b_i        (b_q),
    .sub_i      (sub_q),
    .sum_o      (dp_sum),
    .carry_o    (dp_carry),
    .overflow_o (dp_overflow)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  assign rr_ptr_d  = (32'(winner) == 32'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      a_q            <= '0;
      b_q            <= '0;
      sub_q          <= 1'b0;
      tag_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            sub_q    <= sel_sub;
            tag_q    <= winner;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q   <= dp_sum;
          rsp_carry_q    <= dp_carry;
          rsp_overflow_q <= dp_overflow;
          rsp_id_q       <= tag_q;
          rsp_valid_q    <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign busy         = busy_q;

`ifdef ADDSUB_ARBITER_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] cnt_q;

  // Saturating per-requester handshake counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && any_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (cnt_q[i*CNT_W +: CNT_W] != '1)) begin
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed literal cases plus a long
// randomized run compared every cycle against a transaction-level model.
module tb_addsub_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_result;
  logic            rsp_carry;
  logic            rsp_overflow;
  logic            busy;

  addsub_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  // Returns {overflow, carry, result} from plain arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[W-1:0];
      c = s[W];
      o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b;
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {o, c, r};
  endfunction

  // m_phase: 0 waiting for a request, 1 computing, 2 response pending.
  int           m_phase = 0;
  int           m_ptr   = 0;
  logic         m_known = 1'b0;
  logic         m_just_rst = 1'b0;
  logic [W-1:0] m_a, m_b;
  logic         m_sub;
  int           m_tag;
  logic         m_rv;
  int           m_id;
  logic [W-1:0] m_res;
  logic         m_c, m_o;

  always @(posedge clk) begin
    int w;
    logic [W+1:0] r;
    if (rst) begin
      m_known = 1'b1; m_just_rst = 1'b1;
      m_phase = 0; m_ptr = 0; m_rv = 1'b0;
      m_id = 0; m_res = '0; m_c = 1'b0; m_o = 1'b0;
    end else begin
      m_just_rst = 1'b0;
      if (m_phase == 0) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) begin
          m_a = req_a[w*W +: W]; m_b = req_b[w*W +: W]; m_sub = req_sub[w];
          m_tag = w; m_ptr = (w + 1) % NR; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        r = ref_op(m_a, m_b, m_sub);
        m_res = r[W-1:0]; m_c = r[W]; m_o = r[W+1];
        m_id = m_tag; m_rv = 1'b1; m_phase = 2;
      end else if (rsp_ready) begin
        m_rv = 1'b0; m_phase = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NR-1:0] er;
    int w;
    if (m_known) begin
      er = '0;
      if (m_phase == 0) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) er[w] = 1'b1;
      end
      chk("model_req_ready", 64'(req_ready), 64'(er));
      chk("model_busy", 64'(busy), 64'(m_phase != 0));
      chk("model_rsp_valid", 64'(rsp_valid), 64'(m_rv));
      if (m_rv || m_just_rst) begin
        chk("model_rsp_id", 64'(rsp_id), 64'(m_id));
        chk("model_rsp_result", 64'(rsp_result), 64'(m_res));
        chk("model_rsp_carry", 64'(rsp_carry), 64'(m_c));
        chk("model_rsp_overflow", 64'(rsp_overflow), 64'(m_o));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec,
                        input logic eo, input string nm);
    @(posedge clk); #1;
    req_valid = NR'(1) << r;
    req_a[r*W +: W] = a; req_b[r*W +: W] = b; req_sub[r] = s;
    @(negedge clk);
    chk({nm, "_ready"}, 64'(req_ready), 64'(NR'(1) << r));
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_exec_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_exec_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, "_rsp_id"}, 64'(rsp_id), 64'(r));
    chk({nm, "_result"}, 64'(rsp_result), 64'(er));
    chk({nm, "_carry"}, 64'(rsp_carry), 64'(ec));
    chk({nm, "_overflow"}, 64'(rsp_overflow), 64'(eo));
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return W'($urandom());
    endcase
  endfunction

  int gq_id[$];
  int gq_cyc[$];

  initial begin
    int exp_order[5];
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_flags", 64'({rsp_carry, rsp_overflow}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, "t1_add");
    run_op(1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "t2_sub_borrow");
    run_op(1, 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, "t2_sub");
    run_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "t3_pos_ovf");
    run_op(3, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, "t3_wrap");
    run_op(0, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "t3_neg_ovf");

    // All requesters valid: rotation 0,1,2,3,0 at 3-cycle spacing.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = rnd_op(); req_b[i*W +: W] = rnd_op(); req_sub[i] = 1'($urandom());
    end
    req_valid = '1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int k = 0; k < NR; k++) if (req_ready[k]) gq_id.push_back(k);
        gq_cyc.push_back(cyc);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    exp_order = '{0, 1, 2, 3, 0};
    chk("t4_grant_count_ge5", 64'(gq_id.size() >= 5), 64'd1);
    if (gq_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t4_grant_order", 64'(gq_id[k]), 64'(exp_order[k]));
      for (int k = 1; k < 5; k++) chk("t4_grant_spacing", 64'(gq_cyc[k] - gq_cyc[k-1]), 64'd3);
    end
    repeat (4) @(posedge clk);

    // Back-pressure: response held for several cycles with another request pending.
    #1 rsp_ready = 1'b0;
    req_valid = 4'b0001; req_a[W-1:0] = 32'd100; req_b[W-1:0] = 32'd1; req_sub[0] = 1'b1;
    @(posedge clk); #1 req_valid = 4'b1000;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t5_hold_result", 64'(rsp_result), 64'd99);
      chk("t5_hold_id", 64'(rsp_id), 64'd0);
      chk("t5_hold_ready", 64'(req_ready), 64'd0);
      chk("t5_hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("t5_release_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("t5_after_valid", 64'(rsp_valid), 64'd0);
    chk("t5_after_busy", 64'(busy), 64'd0);

    // Reset during EXEC discards the operation and rewinds the pointer.
    @(posedge clk); #1;
    req_valid = 4'b0100; req_a[2*W +: W] = 32'd9; req_b[2*W +: W] = 32'd4; req_sub[2] = 1'b0;
    @(posedge clk); #1 rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("t6_in_exec_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 rst = 1'b0; req_valid = 4'b1010;
    @(negedge clk);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom());
      for (int k = 0; k < NR; k++) begin
        req_a[k*W +: W] = rnd_op(); req_b[k*W +: W] = rnd_op(); req_sub[k] = 1'($urandom());
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1 req_valid = '0; rst = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
